// File: rtl/pc_unit.sv
// Program-counter unit: registered PC with a four-way next-PC select and a
// circular return-address stack for call/return sequences.
module pc_unit #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] INC       = WIDTH'(1),
  parameter int unsigned     RAS_DEPTH = 4,
  parameter int unsigned     RAS_AW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic [1:0]        sel,
  input  logic [WIDTH-1:0]  target,
  input  logic              call,
  output logic [WIDTH-1:0]  PC,
  output logic [WIDTH-1:0]  pc_plus,
  output logic [WIDTH-1:0]  ras_top,
  output logic [RAS_AW:0]   ras_count,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_udf
);

  localparam int unsigned CW      = RAS_AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_TGT = 2'b01;
  localparam logic [1:0] SEL_RET = 2'b10;

  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [RAS_AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              push;
  logic [WIDTH-1:0]  ras_mem [RAS_DEPTH];

  // Combinational views of registered state
  assign pc_plus   = pc_q + INC;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == DEPTH_C);
  assign ras_top   = ras_empty ? '0 : ras_mem[ptr_q];

  assign PC        = pc_q;
  assign ras_count = cnt_q;
  assign ras_ovf   = ovf_q;
  assign ras_udf   = udf_q;

  // Next-PC selection and stack pointer/count/flag update
  always_comb begin
    pc_d  = pc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    push  = 1'b0;
    if (pc_write) begin
      case (sel)
        SEL_SEQ: pc_d = pc_plus;
        SEL_TGT: begin
          pc_d = target;
          if (call) begin
            push  = 1'b1;
            ptr_d = ptr_q + RAS_AW'(1);
            if (ras_full) ovf_d = 1'b1;   // oldest entry gets overwritten
            else          cnt_d = cnt_q + CW'(1);
          end
        end
        SEL_RET: begin
          if (ras_empty) begin
            pc_d  = pc_plus;
            udf_d = 1'b1;
          end else begin
            pc_d  = ras_mem[ptr_q];
            ptr_d = ptr_q - RAS_AW'(1);
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q  <= RESET_VEC;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Stack storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (rst && push) ras_mem[ptr_d] <= pc_plus;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit. Successor to the plain PC register.
- Holds the PC and selects the next PC from four sources: sequential, target, return, hold.
- Includes a circular return-address stack (RAS) so call/return need no external PC arithmetic.
- Sits at the front of the fetch stage. The hazard unit drives pc_write; control/branch logic drives sel, target and call.

Parameters:
- WIDTH, 32: PC and address width in bits.
- RESET_VEC, 0: PC value loaded on reset.
- INC, 1: sequential increment added to PC.
- RAS_DEPTH, 4: number of RAS entries; power of two, at least 2.
- RAS_AW, 2: RAS pointer width; equals log2(RAS_DEPTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-low (rst=0 resets on the next clk rising edge).
- pc_write  in  1  update enable; 0 stalls the PC and the RAS.
- sel  in  2  next-PC select: 00 sequential, 01 target, 10 return, 11 hold.
- target  in  WIDTH  branch/jump destination, used when sel=01.
- call  in  1  with sel=01, push the return address PC+INC onto the RAS.
- PC  out  WIDTH  current program counter (registered).
- pc_plus  out  WIDTH  PC+INC, combinational from PC.
- ras_top  out  WIDTH  current top-of-stack entry, combinational; 0 when the stack is empty.
- ras_count  out  RAS_AW+1  number of valid entries, 0..RAS_DEPTH.
- ras_empty  out  1  ras_count==0.
- ras_full  out  1  ras_count==RAS_DEPTH.
- ras_ovf  out  1  sticky flag: a push occurred while the stack was full.
- ras_udf  out  1  sticky flag: a return occurred while the stack was empty.

Behaviour:
- Reset (rst=0 at a rising edge):
  - PC=RESET_VEC; ras_count=0; top pointer=0; ras_ovf=0; ras_udf=0.
  - RAS storage contents are don't-care.
  - Reset overrides pc_write, sel and call.
  - Reset in the middle of a call/return sequence discards all stack state.
- Latency: one cycle. PC reflects the selected source on the edge after the inputs are sampled.
- pc_write=0: PC, RAS, count and flags all hold; sel, call and target are ignored.
- pc_write=1, sel=00: PC<=PC+INC, modulo 2^WIDTH (wraps silently, no flag).
- pc_write=1, sel=01: PC<=target.
  - If call=1: push pc_plus (the old PC+INC). Pointer advances, the entry is written, count increments.
  - If call=1 and the stack is full: the oldest entry is overwritten (circular buffer), count stays RAS_DEPTH, ras_ovf<=1.
- pc_write=1, sel=10 (return):
  - Stack not empty: PC<=ras_top; pointer decrements modulo RAS_DEPTH; count decrements.
  - Stack empty: PC<=PC+INC, ras_udf<=1, count stays 0.
- pc_write=1, sel=11: PC holds; RAS and flags unchanged.
- call is ignored when sel is not 01; call with sel=10 never pushes.
- Pointer arithmetic wraps modulo RAS_DEPTH.
- After an overflow, the stack holds the most recent RAS_DEPTH return addresses. Returns pop them newest-first, then underflow.
- Sticky flags clear only on reset.
- Outputs PC, ras_count and the flags are registered. pc_plus, ras_top, ras_empty and ras_full derive combinationally from registered state.

Test Plan:
- Hold rst=0 for 2 cycles, then rst=1, pc_write=1, sel=00 for 3 cycles -> PC=0 during reset, then 1, 2, 3; ras_empty=1.
- PC=3, sel=01, target=0x40, call=1 -> PC=0x40, ras_count=1, ras_top=4. Next: sel=10 -> PC=4, ras_count=0.
- pc_write=0 with sel=01, target=0x99, call=1 for 2 cycles -> PC unchanged, ras_count unchanged. Then pc_write=1, sel=11 -> PC still unchanged.
- Five calls with RAS_DEPTH=4, from PC=0x10,0x20,0x30,0x40,0x50 (each sel=01, call=1) -> ras_full=1, ras_ovf=1, ras_count=4. Four returns yield 0x51,0x41,0x31,0x21. A fifth return gives PC=0x22 and ras_udf=1.
- Load PC=0xFFFFFFFF via sel=01, then sel=00 -> PC=0x00000000, no flags set.
- Two calls, then rst=0 for one cycle -> PC=RESET_VEC, ras_count=0, both flags 0. A following return underflows (ras_udf=1, PC=RESET_VEC+1).
